// File: rtl/cpu_isa_pkg.sv
// Shared ISA constants for the 8-bit lab CPU: opcode groups, immediate-format
// select codes and the fetch-stage state encoding.
package cpu_isa_pkg;

    localparam logic [7:0] OPC_HALT = 8'hFF;

    // 6-bit opcodes carrying a 2-bit immediate in [1:0]
    localparam logic [5:0] OPC6_A = 6'b011000;
    localparam logic [5:0] OPC6_B = 6'b110000;
    localparam logic [5:0] OPC6_C = 6'b110001;
    localparam logic [5:0] OPC6_D = 6'b110010;

    // 4-bit opcodes carrying a 4-bit immediate in [3:0]
    localparam logic [3:0] OPC4_A = 4'b0100;
    localparam logic [3:0] OPC4_B = 4'b0101;
    localparam logic [3:0] OPC4_C = 4'b0111;

    // 3-bit opcodes carrying a 3-bit immediate in [4:2]
    localparam logic [2:0] OPC3_A = 3'b000;
    localparam logic [2:0] OPC3_B = 3'b001;
    localparam logic [2:0] OPC3_C = 3'b100;
    localparam logic [2:0] OPC3_D = 3'b101;

    localparam logic [1:0] IMM_SEL_3B   = 2'b00;
    localparam logic [1:0] IMM_SEL_4B   = 2'b01;
    localparam logic [1:0] IMM_SEL_2B   = 2'b10;
    localparam logic [1:0] IMM_SEL_NONE = 2'b11;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/imm_format_decoder.sv
// Combinational map from an instruction byte to the immediate extractor's
// format select. Earlier matches take priority (HALT before the opcode groups).
module imm_format_decoder
    import cpu_isa_pkg::*;
(
    input  logic [7:0] instr_i,
    output logic [1:0] imm_sel_o
);

    always_comb begin
        imm_sel_o = IMM_SEL_NONE;
        if (instr_i == OPC_HALT) begin
            imm_sel_o = IMM_SEL_NONE;
        end else if (instr_i[7:2] == OPC6_A || instr_i[7:2] == OPC6_B ||
                     instr_i[7:2] == OPC6_C || instr_i[7:2] == OPC6_D) begin
            imm_sel_o = IMM_SEL_2B;
        end else if (instr_i[7:4] == OPC4_A || instr_i[7:4] == OPC4_B ||
                     instr_i[7:4] == OPC4_C) begin
            imm_sel_o = IMM_SEL_4B;
        end else if (instr_i[7:5] == OPC3_A || instr_i[7:5] == OPC3_B ||
                     instr_i[7:5] == OPC3_C || instr_i[7:5] == OPC3_D) begin
            imm_sel_o = IMM_SEL_3B;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, requests instruction memory, latches the returned
// byte into IR with a valid/ready handshake and stops for good on HALT.
//
//   state | meaning
//   BOOT  | one idle cycle after reset, no request
//   FETCH | request outstanding at pc, waiting for imem_valid
//   HOLD  | IR valid, waiting for the consumer (or a redirect)
//   HALT  | HALT consumed; only reset leaves
module instr_fetch_unit
    import cpu_isa_pkg::*;
#(
    parameter int PC_W    = 8,
    parameter int INSTR_W = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic [INSTR_W-1:0] instruction,
    output logic [1:0]         imm_select,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [PC_W-1:0]    pc,
    output logic               halted,
    output logic [CNT_W-1:0]   fetch_count
);

    fetch_state_e       state_q;
    logic [PC_W-1:0]    pc_q;
    logic               req_q;
    logic [INSTR_W-1:0] instr_q;
    logic [1:0]         imm_sel_q;
    logic               valid_q;
    logic               halted_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [1:0]         dec_sel;

    imm_format_decoder u_dec (
        .instr_i   (imem_rdata),
        .imm_sel_o (dec_sel)
    );

    // Counter sticks at all-ones rather than wrapping
    assign count_d = (&count_q) ? count_q : count_q + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_BOOT;
            pc_q      <= '0;
            req_q     <= 1'b0;
            instr_q   <= '0;
            imm_sel_q <= IMM_SEL_NONE;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
            count_q   <= '0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q <= ST_FETCH;
                    req_q   <= 1'b1;
                end
                ST_FETCH: begin
                    // A response racing a redirect belongs to the stale path
                    if (redirect) begin
                        pc_q <= redirect_pc;
                    end else if (imem_valid) begin
                        instr_q   <= imem_rdata;
                        imm_sel_q <= dec_sel;
                        valid_q   <= 1'b1;
                        req_q     <= 1'b0;
                        pc_q      <= pc_q + 1'b1;
                        state_q   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (redirect) begin
                        valid_q <= 1'b0;
                        pc_q    <= redirect_pc;
                        req_q   <= 1'b1;
                        state_q <= ST_FETCH;
                    end else if (instr_ready) begin
                        count_q <= count_d;
                        valid_q <= 1'b0;
                        if (instr_q == OPC_HALT) begin
                            halted_q <= 1'b1;
                            state_q  <= ST_HALT;
                        end else begin
                            req_q   <= 1'b1;
                            state_q <= ST_FETCH;
                        end
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    state_q <= ST_BOOT;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign pc          = pc_q;
    assign instruction = instr_q;
    assign imm_select  = imm_sel_q;
    assign instr_valid = valid_q;
    assign halted      = halted_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, latency, throughput, stall,
// redirects in FETCH and HOLD, PC wrap and HALT.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [7:0]  imem_rdata;
    logic        imem_valid;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic [7:0]  instruction;
    logic [1:0]  imm_select;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  pc;
    logic        halted;
    logic [15:0] fetch_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    instr_fetch_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instruction (instruction),
        .imm_select  (imm_select),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .halted      (halted),
        .fetch_count (fetch_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n     = 1'b0;
        imem_rdata  = 8'h00;
        imem_valid  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        instr_ready = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({imem_req, instr_valid, halted} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=000", {imem_req, instr_valid, halted});
        end
        checks++;
        if (instruction !== 8'h00 || imm_select !== 2'b11) begin
            failures++;
            $display("FAIL reset_ir got=%h/%b want=00/11", instruction, imm_select);
        end
        checks++;
        if (pc !== 8'h00 || fetch_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_pc_cnt got=%h/%0d want=00/0", pc, fetch_count);
        end
        reset_n = 1'b1;
        tick();
        tick();
        // now in FETCH with a request outstanding; reset must drop it at once
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_midreq got=%b want=0", imem_req);
        end
    endtask

    task automatic test_basic();
        do_reset();
        instr_ready = 1'b1;
        checks++;
        if (imem_req !== 1'b0) begin
            failures++;
            $display("FAIL boot_noreq got=%b want=0", imem_req);
        end
        tick();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
                failures++;
                $display("FAIL addr_hold cycle=%0d got=%b/%h want=1/00", i, imem_req, imem_addr);
            end
            if (i == 2) begin
                imem_valid = 1'b1;
                imem_rdata = 8'h24;
            end
            tick();
        end
        imem_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || instruction !== 8'h24 || imm_select !== 2'b00 || pc !== 8'h01) begin
            failures++;
            $display("FAIL basic_ir got=%b/%h/%b/%h want=1/24/00/01", instr_valid, instruction, imm_select, pc);
        end
        tick();
        checks++;
        if (fetch_count !== 16'd1 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_count got=%0d/%b want=1/0", fetch_count, instr_valid);
        end
    endtask

    task automatic test_sequence();
        logic [7:0] data [3];
        logic [1:0] sel  [3];
        int last;
        data[0] = 8'h4A; sel[0] = 2'b01;
        data[1] = 8'h62; sel[1] = 2'b10;
        data[2] = 8'hE0; sel[2] = 2'b11;
        last = 0;
        instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (instr_valid !== 1'b0) begin
                failures++;
                $display("FAIL seq_idle k=%0d got=%b want=0", k, instr_valid);
            end
            imem_valid = 1'b1;
            imem_rdata = data[k];
            tick();
            imem_valid = 1'b0;
            checks++;
            if (instr_valid !== 1'b1 || imm_select !== sel[k] || instruction !== data[k]) begin
                failures++;
                $display("FAIL seq_ir k=%0d got=%b/%b/%h want=1/%b/%h", k, instr_valid, imm_select, instruction, sel[k], data[k]);
            end
            if (k > 0) begin
                checks++;
                if (cyc - last !== 3) begin
                    failures++;
                    $display("FAIL seq_period k=%0d got=%0d want=3", k, cyc - last);
                end
            end
            last = cyc;
            tick();
        end
        checks++;
        if (pc !== 8'h04 || fetch_count !== 16'd4) begin
            failures++;
            $display("FAIL seq_end got=%h/%0d want=04/4", pc, fetch_count);
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        imem_valid = 1'b1;
        imem_rdata = 8'h53;
        tick();
        imem_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (instruction !== 8'h53 || imm_select !== 2'b01 || pc !== 8'h01 ||
                imem_req !== 1'b0 || instr_valid !== 1'b1 || fetch_count !== 16'd0) begin
                failures++;
                $display("FAIL stall_hold i=%0d got=%h/%b/%h/%b/%b/%0d want=53/01/01/0/1/0",
                         i, instruction, imm_select, pc, imem_req, instr_valid, fetch_count);
            end
            tick();
        end
        instr_ready = 1'b1;
        tick();
        checks++;
        if (fetch_count !== 16'd1 || instr_valid !== 1'b0 || imem_req !== 1'b1) begin
            failures++;
            $display("FAIL stall_release got=%0d/%b/%b want=1/0/1", fetch_count, instr_valid, imem_req);
        end
    endtask

    task automatic test_redirect_fetch();
        redirect    = 1'b1;
        redirect_pc = 8'h80;
        imem_valid  = 1'b1;
        imem_rdata  = 8'h24;
        tick();
        redirect   = 1'b0;
        imem_valid = 1'b0;
        checks++;
        if (imem_addr !== 8'h80 || imem_req !== 1'b1 || instr_valid !== 1'b0) begin
            failures++;
            $display("FAIL rfetch_addr got=%h/%b/%b want=80/1/0", imem_addr, imem_req, instr_valid);
        end
        checks++;
        if (instruction !== 8'h53 || fetch_count !== 16'd1) begin
            failures++;
            $display("FAIL rfetch_discard got=%h/%0d want=53/1", instruction, fetch_count);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b0 || imem_addr !== 8'h80) begin
            failures++;
            $display("FAIL rfetch_after got=%b/%h want=0/80", instr_valid, imem_addr);
        end
    endtask

    task automatic test_redirect_hold();
        imem_valid = 1'b1;
        imem_rdata = 8'h4A;
        tick();
        imem_valid = 1'b0;
        checks++;
        if (instr_valid !== 1'b1 || pc !== 8'h81) begin
            failures++;
            $display("FAIL rhold_enter got=%b/%h want=1/81", instr_valid, pc);
        end
        redirect    = 1'b1;
        redirect_pc = 8'h10;
        instr_ready = 1'b1;
        tick();
        redirect = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || fetch_count !== 16'd1 || imem_addr !== 8'h10 || imem_req !== 1'b1) begin
            failures++;
            $display("FAIL rhold_redir got=%b/%0d/%h/%b want=0/1/10/1", instr_valid, fetch_count, imem_addr, imem_req);
        end
        imem_valid = 1'b1;
        imem_rdata = 8'h62;
        tick();
        imem_valid = 1'b0;
        checks++;
        if (imm_select !== 2'b10) begin
            failures++;
            $display("FAIL rhold_fetch got=%b want=10", imm_select);
        end
        tick();
        checks++;
        if (fetch_count !== 16'd2 || pc !== 8'h11) begin
            failures++;
            $display("FAIL rhold_accept got=%0d/%h want=2/11", fetch_count, pc);
        end
    endtask

    task automatic test_halt_wrap();
        redirect    = 1'b1;
        redirect_pc = 8'hFF;
        tick();
        redirect = 1'b0;
        checks++;
        if (imem_addr !== 8'hFF) begin
            failures++;
            $display("FAIL halt_addr got=%h want=ff", imem_addr);
        end
        imem_valid = 1'b1;
        imem_rdata = 8'hFF;
        tick();
        imem_valid = 1'b0;
        checks++;
        if (pc !== 8'h00 || imm_select !== 2'b11 || instr_valid !== 1'b1) begin
            failures++;
            $display("FAIL halt_wrap got=%h/%b/%b want=00/11/1", pc, imm_select, instr_valid);
        end
        tick();
        checks++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_count !== 16'd3) begin
            failures++;
            $display("FAIL halt_enter got=%b/%b/%b/%0d want=1/0/0/3", halted, imem_req, instr_valid, fetch_count);
        end
        redirect    = 1'b1;
        redirect_pc = 8'h20;
        for (int i = 0; i < 20; i++) begin
            imem_valid = i[0];
            tick();
            checks++;
            if (imem_req !== 1'b0 || halted !== 1'b1 || pc !== 8'h00) begin
                failures++;
                $display("FAIL halt_stay i=%0d got=%b/%b/%h want=0/1/00", i, imem_req, halted, pc);
            end
        end
        redirect   = 1'b0;
        imem_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (halted !== 1'b0 || fetch_count !== 16'd0 || pc !== 8'h00) begin
            failures++;
            $display("FAIL halt_reset got=%b/%0d/%h want=0/0/00", halted, fetch_count, pc);
        end
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_sequence();
        test_stall();
        test_redirect_fetch();
        test_redirect_hold();
        test_halt_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
